// File: rtl/sp_fifo_pkg.sv
// sp_fifo_pkg: shared constants and types for blocks on the FIFO read side
package sp_fifo_pkg;

    // Read data appears this many cycles after an accepted rd_en
    localparam int FIFO_READ_LATENCY = 1;

    // Output buffer depth of the stream adapter
    localparam int STREAM_BUF_DEPTH = 2;

    // Occupancy of the 2-entry stream buffer (0..2)
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_read_stream_adapter_stream_buffer2.sv
// stream_buffer2: 2-entry in-order register buffer with push, pop and occupancy
module stream_buffer2
    import sp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output occ_t                  occ_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d, second_q, second_d;
    occ_t                  occ_q, occ_d, occ_mid;

    // A pop frees the head first, so a same-cycle push lands in whichever slot is then next free
    always_comb begin
        occ_mid  = occ_q - occ_t'(pop_i);
        occ_d    = occ_mid + occ_t'(push_i);
        head_d   = (pop_i && occ_q == 2'd2) ? second_q :
                   (push_i && occ_mid == 2'd0) ? push_data_i : head_q;
        second_d = (push_i && occ_mid == 2'd1) ? push_data_i : second_q;
    end

    // Buffer registers, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= '0;
            head_q   <= '0;
            second_q <= '0;
        end else begin
            occ_q    <= occ_d;
            head_q   <= head_d;
            second_q <= second_d;
        end
    end

    assign head_o = head_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_read_stream_adapter.sv
// fifo_read_stream_adapter: turns a 1-cycle-latency FIFO read port into a valid/ready stream
module fifo_read_stream_adapter
    import sp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_en,
    input  logic                   empty,
    input  logic                   almost_empty,
    input  logic [COUNT_WIDTH-1:0] rd_data_count,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_almost_empty,
    output logic [COUNT_WIDTH+1:0] level
);

    if (FIFO_READ_LATENCY != 1) begin : g_latency_check
        $error("fifo_read_stream_adapter only supports a FIFO read latency of 1");
    end

    logic inflight_q;
    logic pop;
    occ_t occ;

    stream_buffer2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk         (clock),
        .rst         (reset),
        .push_i      (inflight_q && !reset),
        .push_data_i (rd_data),
        .pop_i       (pop),
        .head_o      (m_data),
        .occ_o       (occ)
    );

    assign pop            = m_valid && m_ready;
    assign m_valid        = occ != 2'd0;
    assign m_almost_empty = almost_empty;
    // Issue only while buffered plus in-flight words, after this cycle's pop, leave a free slot
    assign rd_en          = !empty && !reset && ({1'b0, occ} + 3'(inflight_q) - 3'(pop)) < 3'd2;
    assign level          = (COUNT_WIDTH+2)'(rd_data_count) + (COUNT_WIDTH+2)'(occ) + (COUNT_WIDTH+2)'(inflight_q);

    // Remember an issued read so its returning word is captured next cycle
    always_ff @(posedge clock) begin
        if (reset) inflight_q <= 1'b0;
        else       inflight_q <= rd_en;
    end

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// tb_fifo_read_stream_adapter: FIFO model plus word scoreboard driving the stream adapter
module tb_fifo_read_stream_adapter;

    localparam int DW = 32;
    localparam int CW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          empty = 1'b1;
    logic          almost_empty = 1'b1;
    logic          m_ready = 1'b0;
    logic          rd_en, m_valid, m_almost_empty;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_data_count = '0;
    logic [CW+1:0] level;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb_d[$];
    int            sb_c[$];
    logic [DW-1:0] beats[$];
    int cyc = 0, n_rd = 0, n_beat = 0, first_beat = 0, last_beat = 0;
    bit prev_reset = 1'b0;

    always #5 clock = ~clock;

    fifo_read_stream_adapter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .rd_data_count  (rd_data_count),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_almost_empty (m_almost_empty),
        .level          (level)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        empty         = fq.size() == 0;
        rd_data_count = CW'(fq.size());
        almost_empty  = fq.size() < 3;
    endtask

    task automatic clear_counts();
        n_rd = 0;
        n_beat = 0;
        beats.delete();
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance FIFO and scoreboard
    task automatic step();
        bit            exp_valid, have_rd;
        logic [DW-1:0] nd;
        drive();
        #3;
        exp_valid = sb_c.size() > 0 && sb_c[0] <= cyc - 2;
        check("rd_en_while_empty", rd_en && empty, 0);
        check("almost_empty_pass", m_almost_empty, almost_empty);
        if (reset) begin
            check("rd_en_in_reset", rd_en, 0);
            if (prev_reset) begin
                check("m_valid_in_reset", m_valid, 0);
                check("m_data_in_reset", m_data, 0);
                check("level_in_reset", level, rd_data_count);
            end
        end else begin
            check("m_valid", m_valid, exp_valid);
            if (exp_valid) check("m_data", m_data, sb_d[0]);
            check("level", level, fq.size() + sb_d.size());
            check("rd_en", rd_en, !empty && (sb_d.size() - int'(exp_valid && m_ready)) < 2);
            check("occ_inflight_bound", (level - rd_data_count) <= 2, 1);
        end
        have_rd = 1'b0;
        nd = '0;
        if (!reset && exp_valid && m_ready) begin
            beats.push_back(sb_d.pop_front());
            void'(sb_c.pop_front());
            if (n_beat == 0) first_beat = cyc;
            last_beat = cyc;
            n_beat++;
        end
        if (rd_en && fq.size() > 0) begin
            nd = fq.pop_front();
            sb_d.push_back(nd);
            sb_c.push_back(cyc);
            have_rd = 1'b1;
            n_rd++;
        end
        if (reset) begin
            sb_d.delete();
            sb_c.delete();
        end
        prev_reset = reset;
        @(posedge clock);
        #1;
        cyc++;
        rd_data = have_rd ? nd : DW'($urandom());
    endtask

    initial begin
        int rel, word, gap, lim;
        // Reset with data waiting, then a full-rate burst of 8 words
        for (int i = 0; i < 8; i++) fq.push_back(DW'(32'h10 + i));
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        m_ready = 1'b1;
        clear_counts();
        rel = cyc;
        repeat (14) step();
        check("burst_beats", n_beat, 8);
        for (int i = 0; i < 8 && i < beats.size(); i++) check("burst_order", beats[i], 32'h10 + i);
        check("burst_first_latency", first_beat - rel, 2);
        check("burst_no_bubbles", last_beat - first_beat, 7);
        drive();
        #1;
        check("burst_level_drained", level, 0);
        check("burst_valid_drained", m_valid, 0);
        // Backpressure: 10 cycles with m_ready low, then resume
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fq.push_back(DW'(32'h10 + i));
        clear_counts();
        repeat (10) step();
        check("bp_rd_pulses", n_rd, 2);
        check("bp_m_valid", m_valid, 1);
        check("bp_m_data", m_data, 32'h10);
        drive();
        #1;
        check("bp_level", level, 8);
        m_ready = 1'b1;
        repeat (12) step();
        check("bp_resume_beats", n_beat, 8);
        check("bp_resume_span", last_beat - first_beat, 7);
        // Reset one cycle after an rd_en drops the returning word
        for (int i = 0; i < 4; i++) fq.push_back(DW'(32'h20 + i));
        clear_counts();
        step();
        check("drop_rd_issued", n_rd, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive();
        #1;
        check("drop_m_valid", m_valid, 0);
        check("drop_level", level, rd_data_count);
        check("drop_level_value", level, 3);
        repeat (8) step();
        check("drop_beats", n_beat, 3);
        if (beats.size() > 0) check("drop_first_word", beats[0], 32'h21);
        // A single word through an otherwise empty FIFO
        clear_counts();
        fq.push_back(DW'(32'h55));
        repeat (8) step();
        check("single_rd_pulses", n_rd, 1);
        check("single_beats", n_beat, 1);
        if (beats.size() > 0) check("single_word", beats[0], 32'h55);
        check("single_idle", m_valid, 0);
        // Random backpressure and producer gaps over 1000 words
        clear_counts();
        word = 0;
        gap = 0;
        lim = cyc + 20000;
        while (n_beat < 1000 && cyc < lim) begin
            m_ready = $urandom_range(0, 1) == 1;
            if (gap > 0) gap--;
            else if ($urandom_range(0, 19) == 0) gap = $urandom_range(5, 15);
            else if (word < 1000 && $urandom_range(0, 1) == 1) begin
                fq.push_back(DW'(32'h1000 + word));
                word++;
            end
            step();
        end
        check("random_beats", n_beat, 1000);
        for (int i = 0; i < beats.size(); i++) check("random_order", beats[i], 32'h1000 + i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_stream_adapter.md
# fifo_read_stream_adapter

Downstream consumer of a `fifo_read_interface` slave port. It converts the FIFO's standard-mode read side into a registered valid/ready stream for the next pipeline stage. The FIFO read side has 1-cycle read latency, `rd_en` and `empty`. The adapter prefetches into a 2-entry output buffer, so the stream sustains one word per cycle and never over-reads the FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of `rd_data` and `m_data`.
- `COUNT_WIDTH`, default 10: width of the FIFO's `rd_data_count`.

Ports:
- `clock`  in  1: single clock for the block and the FIFO read side.
- `reset`  in  1: synchronous, active-high reset.
- `rd_data`  in  DATA_WIDTH: FIFO read data, valid exactly 1 cycle after an accepted `rd_en`.
- `rd_en`  out  1: FIFO read enable.
- `empty`  in  1: FIFO empty flag.
- `almost_empty`  in  1: passed through to `m_almost_empty`; has no other use inside the block.
- `rd_data_count`  in  COUNT_WIDTH: FIFO fill level.
- `m_data`  out  DATA_WIDTH: stream data (buffer head register).
- `m_valid`  out  1: stream valid.
- `m_ready`  in  1: stream ready from the downstream stage.
- `m_almost_empty`  out  1: equals `almost_empty`.
- `level`  out  COUNT_WIDTH+2: total words not yet delivered on the stream.

## Operation
- State:
  - `occ` (0..2): number of words held in the output buffer.
  - `inflight` (0..1): 1 when `rd_en` was asserted in the previous cycle.
- `pop` = `m_valid && m_ready`.
- `rd_en` = `!empty && !reset && (occ + inflight - pop) < 2`.
  - Combinational from `empty`, `m_ready` and registered state.
  - `rd_en` is never asserted while `empty`=1.
- Capture: when `inflight`=1, `rd_data` is written into the buffer.
  - If the buffer is empty after this cycle's pop, the word goes to the head; otherwise it goes to the second slot.
- On pop: the second slot moves to the head.
  - Pop and capture in the same cycle are both honoured.
  - Word order is strictly FIFO order.
- `m_valid` = (`occ` != 0). `m_data` = head register.
  - While `m_valid`=1 and `m_ready`=0, `m_data` and `m_valid` hold stable (AXI-stream rule).
- `level` = zero-extended `rd_data_count` + `occ` + `inflight`, computed combinationally.
  - The width COUNT_WIDTH+2 cannot overflow.
- Invariant: `occ + inflight` ≤ 2 at every clock edge. The bench asserts it.
- Reset, at any time including mid-operation:
  - `occ`=0, `inflight`=0, head and second slot cleared to 0.
  - A word returning from an in-flight read in the reset cycle is discarded.
  - The FIFO is reset from the same `reset` in the same cycle.
- Reset values of outputs: `rd_en`=0, `m_valid`=0, `m_data`=0, `level`=`rd_data_count`.

## Timing
- Latency from `empty` falling (cycle N, buffer idle) to output:
  - `rd_en`=1 in cycle N.
  - Data captured at the end of cycle N+1.
  - `m_valid`=1 in cycle N+2.
- Throughput: with `empty`=0 and `m_ready`=1 held, one word per cycle after the first, with no bubbles.
- Backpressure: when `m_ready` drops, at most 2 words are buffered. `rd_en` deasserts in the same cycle the limit would be exceeded.
- Resumption: when `m_ready` rises with `occ`=2, words pop back-to-back. The next `rd_en` issues in the same cycle as the first pop.
- FIFO drains to empty mid-burst: `rd_en` falls in the same cycle as `empty`. The in-flight word is still captured. `m_valid` falls after the last buffered word pops.
- Simultaneous capture, pop and issue in one cycle: `occ` is unchanged and `inflight` stays 1.

## Structure
- Shared package `sp_fifo_pkg`: constant `FIFO_READ_LATENCY = 1`, plus a static elaboration check that the block is only instantiated against that latency.
- Natural sub-module `stream_buffer2`: 2-entry register buffer with a push port, a pop port and an occupancy output.
- The top level holds only the issue logic, the `inflight` flag and `level`.

## Test plan
- Reset with `empty`=0 held → `rd_en`=0 and `m_valid`=0 in the reset cycle; first `rd_en` in the cycle after reset releases; `m_valid` 2 cycles later.
- Preload 8 words 0x10..0x17, hold `m_ready`=1 → 8 consecutive `m_valid` cycles with data 0x10..0x17 in order, then `m_valid`=0. `level` goes 8 → 0 and never underflows.
- Preload 8 words, `m_ready`=0 for 10 cycles → exactly 2 `rd_en` pulses; `m_data`=0x10 stable; `level`=8 throughout.
- Random `m_ready` (50%) with random `empty` gaps over 1000 words → scoreboard matches order with no loss or duplication. `rd_en` never asserted while `empty`=1. `occ + inflight` ≤ 2 on every edge.
- Assert `reset` in the cycle after an `rd_en` → returning word dropped; `m_valid`=0 and `level`=`rd_data_count` on the next cycle.
- `empty` falls for a single word only → one `rd_en` pulse, one `m_valid` beat, then idle.
